// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and buffer entry layout for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0033;
    localparam logic [6:0]  JAL_OPCODE = 7'b110_1111;
    localparam int          ENTRY_W    = 65;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        predicted;
    } fetch_entry_t;

    function automatic logic [31:0] j_immediate(input logic [31:0] word);
        return {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
interface fetch_if;

    logic        instruction_request;
    logic [31:0] instruction_address;
    logic        instruction_response;
    logic [31:0] instruction_data;

    modport master (
        output instruction_request,
        output instruction_address,
        input  instruction_response,
        input  instruction_data
    );

    modport slave (
        input  instruction_request,
        input  instruction_address,
        output instruction_response,
        output instruction_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two ring with wrapping pointers and a registered head.
module fetch_fifo #(
    parameter int               DEPTH       = 4,
    parameter int               WIDTH       = 65,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = {WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_next_s;
    logic [CW-1:0]    count_r, remain_s, count_next_s;
    logic             push_ok_s, pop_ok_s, valid_next_s, valid_r;
    logic [WIDTH-1:0] data_next_s, data_r;

    // Accepted push/pop and the head that will be visible after this edge.
    always_comb begin
        pop_ok_s      = pop && (count_r != {CW{1'b0}});
        push_ok_s     = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
        rd_ptr_next_s = pop_ok_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
        remain_s      = count_r - CW'(pop_ok_s);
        count_next_s  = remain_s + CW'(push_ok_s);
        if (flush) begin
            valid_next_s = 1'b0;
            data_next_s  = EMPTY_VALUE;
        end else if (remain_s == {CW{1'b0}}) begin
            valid_next_s = push_ok_s;
            data_next_s  = push_ok_s ? push_data : EMPTY_VALUE;
        end else begin
            valid_next_s = 1'b1;
            data_next_s  = mem_r[rd_ptr_next_s];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= EMPTY_VALUE;
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= EMPTY_VALUE;
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            count_r  <= count_next_s;
            valid_r  <= valid_next_s;
            data_r   <= data_next_s;
        end
    end

    // Entry storage; contents beyond the occupied window are don't-care.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign count     = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with prefetch buffer and redirect/drain handling.
// Define FETCH_JAL_PREDICT_EN to follow JAL targets at fetch time.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus,
    input  logic        redirect,
    input  logic [31:0] redirect_address,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic        fetch_predicted
);

    localparam int           CW          = $clog2(DEPTH) + 1;
    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP, predicted: 1'b0};

    fetch_state_e state_r, state_next_s;
    logic         request_r, request_next_s;
    logic [31:0]  address_r, address_next_s, target_r, target_next_s;
    logic [31:0]  redirect_target_s, next_address_s;
    logic         xfer_s, pending_s, push_s, pop_s, room_s, jal_s;
    logic [CW-1:0] count_s, count_next_s;
    fetch_entry_t push_entry_s, head_s;

    assign xfer_s            = request_r && bus.instruction_response;
    assign pending_s         = request_r && !bus.instruction_response;
    assign redirect_target_s = redirect_address & 32'hFFFF_FFFC;
    assign push_s            = xfer_s && (state_r == FETCH) && !redirect;
    assign pop_s             = fetch_valid && fetch_ready && !redirect;
    assign count_next_s      = redirect ? {CW{1'b0}} : count_s + CW'(push_s) - CW'(pop_s);
    assign room_s            = (count_next_s != CW'(DEPTH));
    assign push_entry_s      = '{pc: address_r, instr: bus.instruction_data, predicted: jal_s};

    // Address following the word completing this cycle.
    always_comb begin
`ifdef FETCH_JAL_PREDICT_EN
        jal_s          = (bus.instruction_data[6:0] == JAL_OPCODE);
        next_address_s = jal_s ? address_r + j_immediate(bus.instruction_data)
                               : address_r + 32'd4;
`else
        jal_s          = 1'b0;
        next_address_s = address_r + 32'd4;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a redirect over a live transfer must wait for it in DRAIN.
    always_comb begin
        state_next_s = state_r;
        if (redirect) begin
            state_next_s = pending_s ? DRAIN : FETCH;
        end else begin
            case (state_r)
                FETCH:   state_next_s = room_s ? FETCH : IDLE;
                IDLE:    state_next_s = room_s ? FETCH : IDLE;
                DRAIN:   state_next_s = xfer_s ? FETCH : DRAIN;
                default: state_next_s = FETCH;
            endcase
        end
    end

    // FSM outputs: next bus request, bus address and pending restart target.
    always_comb begin
        request_next_s = request_r;
        address_next_s = address_r;
        target_next_s  = target_r;
        if (redirect) begin
            target_next_s  = redirect_target_s;
            request_next_s = 1'b1;
            if (pending_s) begin
                address_next_s = address_r;
            end else begin
                address_next_s = redirect_target_s;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (xfer_s) begin
                        address_next_s = next_address_s;
                    end else begin
                        address_next_s = address_r;
                    end
                    request_next_s = pending_s || room_s;
                end
                IDLE: begin
                    request_next_s = room_s;
                end
                DRAIN: begin
                    if (xfer_s) begin
                        address_next_s = target_r;
                    end else begin
                        address_next_s = address_r;
                    end
                    request_next_s = 1'b1;
                end
                default: begin
                    request_next_s = 1'b0;
                end
            endcase
        end
    end

    // Registered bus request, address and restart target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            request_r <= 1'b0;
            address_r <= BOOT_ADDRESS;
            target_r  <= 32'h0000_0000;
        end else begin
            request_r <= request_next_s;
            address_r <= address_next_s;
            target_r  <= target_next_s;
        end
    end

    fetch_fifo #(
        .DEPTH       (DEPTH),
        .WIDTH       (ENTRY_W),
        .EMPTY_VALUE (EMPTY_ENTRY)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .out_valid (fetch_valid),
        .out_data  (head_s),
        .count     (count_s)
    );

    assign bus.instruction_request = request_r;
    assign bus.instruction_address = address_r;
    assign fetch_instruction       = head_s.instr;
    assign fetch_pc                = head_s.pc;
    assign fetch_predicted         = head_s.predicted;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDRESS, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instruction_request  output  1  bus request valid.
REQ-006 SHALL have port instruction_address  output  32  word address of request.
REQ-007 SHALL have port instruction_response  input  1  bus completes transfer this cycle.
REQ-008 SHALL have port instruction_data  input  32  fetched word, valid with response.
REQ-009 SHALL have port redirect  input  1  flush and restart fetch (branch/jump/trap).
REQ-010 SHALL have port redirect_address  input  32  restart address; bits [1:0] ignored.
REQ-011 SHALL have port fetch_valid  output  1  buffer head valid.
REQ-012 SHALL have port fetch_ready  input  1  decode accepts head.
REQ-013 SHALL have port fetch_instruction  output  32  head instruction; 32'h00000033 (NOP) when empty.
REQ-014 SHALL have port fetch_pc  output  32  head PC; 0 when empty.
REQ-015 SHALL have port fetch_predicted  output  1  head entry was JAL-redirected by prediction.

Function
REQ-016 SHALL complete a bus transfer in every cycle with instruction_request && instruction_response; one transfer outstanding max.
REQ-017 SHALL hold instruction_address stable while instruction_request high and response low.
REQ-018 SHALL use FSM states FETCH, DRAIN, IDLE: FETCH requests when buffer not full; IDLE when full (request low); IDLE->FETCH when an entry frees.
REQ-019 SHALL allow a completing response to push while full only if a pop happens the same cycle; otherwise no request issued when count == DEPTH.
REQ-020 SHALL push {pc, data, predicted} one cycle after response; head visible at outputs next cycle (response N -> fetch_valid N+1).
REQ-021 SHALL pop head on fetch_valid && fetch_ready; simultaneous push and pop keeps count constant.
REQ-022 SHALL advance fetch address by 4 per completed transfer, wrapping 32'hFFFFFFFC -> 0.
REQ-023 On redirect: SHALL empty buffer same edge, set fetch address to {redirect_address[31:2],2'b00}; if transfer pending (request high, response low) enter DRAIN, else FETCH.
REQ-024 In DRAIN: SHALL keep old request/address until response, discard its data, then request redirect address next cycle.
REQ-025 Redirect in same cycle as response: redirect wins, data discarded, no DRAIN.
REQ-026 Redirect while in DRAIN: SHALL latch newest redirect address, stay in DRAIN.
REQ-027 fetch_valid SHALL be 0 in the cycle after redirect.

Reset
REQ-028 During reset: instruction_request 0, instruction_address BOOT_ADDRESS, fetch_valid 0, fetch_instruction NOP, fetch_pc 0, fetch_predicted 0, buffer empty, state FETCH.
REQ-029 First request SHALL assert the cycle after reset deasserts; reset mid-transfer abandons it without DRAIN.

Configuration
REQ-030 Macro FETCH_JAL_PREDICT_EN defined: response word with opcode 7'b1101111 SHALL set next fetch address to its pc + J-immediate, entry predicted=1.
REQ-031 Macro undefined: sequential fetch only, fetch_predicted tied 0, no J-immediate logic.

Structure
REQ-032 SHALL put NOP, JAL_OPCODE, FSM state encoding in shared package fetch_pkg.
REQ-033 SHALL implement buffer as sub-module fetch_fifo (DEPTH, WIDTH=65), pointer-wrap, registered outputs.

Verification
REQ-034 Reset release, response always 1, fetch_ready 1 -> addresses 0,4,8,...; fetch_pc 0 valid one cycle after first response.
REQ-035 fetch_ready 0, DEPTH=4 -> exactly 4 transfers, then request 0; fetch_ready 1 one cycle -> one new request.
REQ-036 Request to 0x10 pending with response 0, redirect to 0x203 -> address held 0x10 until response, data dropped, next request 0x200.
REQ-037 Redirect and response same cycle to 0x80 -> no push, next request 0x80, fetch_valid 0 next cycle.
REQ-038 Redirect to 0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000.
REQ-039 FETCH_JAL_PREDICT_EN, word 0x0100006F at 0x40 -> next request 0x50, entry fetch_predicted 1.
